// File: rtl/sd_pkg.sv
// -----------------------------------------------------------------------------
// sd_pkg: shared definitions for the sigma-delta ADC receive path.
//   cic_width()   - internal CIC word width for a given ratelog2 (2*ratelog2+1)
//   clamp_align() - clamp a CIC result to 2*ratelog2 bits and left-align it
//                   into a signalwidth-bit unsigned sample
//   PRIME_TICKS   - decimation ticks discarded after reset
//   SYNC_STAGES   - flops in the comparator input synchroniser
// -----------------------------------------------------------------------------
package sd_pkg;

  localparam int PRIME_TICKS = 2;
  localparam int SYNC_STAGES = 2;

  // A 2nd-order CIC with ratio 2^rl2 grows by 2*rl2 bits over a 1-bit input.
  function automatic int cic_width(input int rl2);
    return 2 * rl2 + 1;
  endfunction

  // Full scale R^2 cannot be represented in 2*rl2 bits, so it is pulled down
  // to R^2-1. The result sits in the low sw bits of the return value.
  function automatic logic [31:0] clamp_align(input logic [31:0] raw,
                                              input int          rl2,
                                              input int          sw);
    logic [31:0] full_scale;
    logic [31:0] v;
    full_scale = (32'd1 << (2 * rl2)) - 32'd1;
    v          = (raw > full_scale) ? full_scale : raw;
    if (2 * rl2 >= sw) begin
      return v >> (2 * rl2 - sw);
    end else begin
      return v << (sw - 2 * rl2);
    end
  endfunction

endpackage

// File: rtl/sd_adc_decimator_cic2.sv
// -----------------------------------------------------------------------------
// cic2_decimator: 2nd-order CIC decimator by R = 2^ratelog2 for a 0/1 input.
//   clk          - system clock
//   reset_n      - synchronous active-low reset
//   x            - 1-bit input sample (unsigned 0/1)
//   c2           - comb output, valid while sample_valid is high
//   sample_valid - one-clock pulse, two clocks after each primed tick
// All arithmetic is modular in cic_width(ratelog2) bits; wrap-around in the
// integrators cancels in the combs, so nothing saturates here.
// -----------------------------------------------------------------------------
module cic2_decimator
  import sd_pkg::*;
#(
  parameter int ratelog2 = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  x,
  output logic [2*ratelog2:0]   c2,
  output logic                  sample_valid
);

  localparam int W = cic_width(ratelog2);
  localparam logic [ratelog2-1:0] PHASE_LAST = '1;

  logic [W-1:0]        i1_r;
  logic [W-1:0]        i2_r;
  logic [W-1:0]        i2_d_r;
  logic [W-1:0]        c1_r;
  logic [W-1:0]        c1_d_r;
  logic [W-1:0]        c2_r;
  logic [ratelog2-1:0] phase_r;
  logic [1:0]          prime_r;
  logic                t1_r;
  logic                v1_r;
  logic                v2_r;
  logic                tick_s;
  logic                primed_s;

  assign tick_s   = (phase_r == PHASE_LAST);
  assign primed_s = (prime_r == 2'(PRIME_TICKS));

  // Integrators and free-running phase counter, advanced every clock.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      i1_r    <= '0;
      i2_r    <= '0;
      phase_r <= '0;
    end else begin
      i1_r    <= i1_r + W'(x);
      i2_r    <= i2_r + i1_r;
      phase_r <= phase_r + ratelog2'(1);
    end
  end

  // First comb stage and priming counter, both driven by the decimation tick.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      c1_r    <= '0;
      i2_d_r  <= '0;
      prime_r <= 2'd0;
    end else if (tick_s) begin
      c1_r   <= i2_r - i2_d_r;
      i2_d_r <= i2_r;
      if (!primed_s) begin
        prime_r <= prime_r + 2'd1;
      end
    end
  end

  // Second comb stage, one clock behind the tick.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      c2_r   <= '0;
      c1_d_r <= '0;
    end else if (t1_r) begin
      c2_r   <= c1_r - c1_d_r;
      c1_d_r <= c1_r;
    end
  end

  // Tick pipeline: t1 steps the second comb; v1/v2 carry only primed ticks
  // so priming samples never reach the output.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      t1_r <= 1'b0;
      v1_r <= 1'b0;
      v2_r <= 1'b0;
    end else begin
      t1_r <= tick_s;
      v1_r <= tick_s & primed_s;
      v2_r <= v1_r;
    end
  end

  assign c2           = c2_r;
  assign sample_valid = v2_r;

endmodule

// File: rtl/sd_adc_decimator.sv
// -----------------------------------------------------------------------------
// sd_adc_decimator: receive end of a 1-bit sigma-delta link. Samples an
// external comparator, drives the RC feedback pin and decimates the resulting
// bitstream into unsigned PCM samples.
//   clk     - system clock
//   reset_n - synchronous active-low reset
//   d       - comparator output, asynchronous to clk
//   fb      - feedback drive to the RC network (d delayed by 3 clocks)
//   q       - unsigned PCM sample, signalwidth bits, held between strobes
//   q_valid - one-clock strobe when q is updated
// Optional build macro SD_ADC_IIR_EN: routes samples through iirfilter
// (cbits=2, immediate=0) and delays q_valid by one more clock.
// -----------------------------------------------------------------------------
module sd_adc_decimator
  import sd_pkg::*;
#(
  parameter int signalwidth = 16,
  parameter int ratelog2    = 6
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   d,
  output logic                   fb,
  output logic [signalwidth-1:0] q,
  output logic                   q_valid
);

  logic [SYNC_STAGES-1:0]          sync_r;
  logic [cic_width(ratelog2)-1:0]  c2_s;
  logic                            sample_valid_s;
  logic [signalwidth-1:0]          sample_s;

  // Comparator synchroniser; fb is the synchronised bit registered once more,
  // and that same registered bit is what the CIC integrates.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_r <= '0;
      fb     <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], d};
      fb     <= sync_r[SYNC_STAGES-1];
    end
  end

  cic2_decimator #(
    .ratelog2     (ratelog2)
  ) u_cic (
    .clk          (clk),
    .reset_n      (reset_n),
    .x            (fb),
    .c2           (c2_s),
    .sample_valid (sample_valid_s)
  );

  assign sample_s = signalwidth'(clamp_align(32'(c2_s), ratelog2, signalwidth));

`ifdef SD_ADC_IIR_EN
  logic [signalwidth-1:0] iir_q_s;
  logic                   iir_valid_r;

  iirfilter #(
    .signalwidth (signalwidth),
    .cbits       (2),
    .immediate   (0)
  ) u_iir (
    .clk         (clk),
    .reset_n     (reset_n),
    .ena         (sample_valid_s),
    .d           (sample_s),
    .q           (iir_q_s)
  );

  // Filter output settles one clock after its enable; strobe follows it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      iir_valid_r <= 1'b0;
      q_valid     <= 1'b0;
      q           <= '0;
    end else begin
      iir_valid_r <= sample_valid_s;
      q_valid     <= iir_valid_r;
      if (iir_valid_r) begin
        q <= iir_q_s;
      end
    end
  end
`else
  // Output register: capture the aligned sample on each primed strobe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_valid <= 1'b0;
      q       <= '0;
    end else begin
      q_valid <= sample_valid_s;
      if (sample_valid_s) begin
        q <= sample_s;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sd_adc_decimator.sv
// -----------------------------------------------------------------------------
// tb_sd_adc_decimator: self-checking bench for sd_adc_decimator with
// signalwidth=16, ratelog2=4 (R=16), filter macro undefined.
// Expected samples come from a moving-sum-of-moving-sum over the bitstream
// history the bench itself applied.
// -----------------------------------------------------------------------------
module tb_sd_adc_decimator;

  localparam int SW   = 16;
  localparam int RL2  = 4;
  localparam int R    = 16;
  localparam int MAXE = 16384;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          d = 1'b0;
  logic          fb;
  logic [SW-1:0] q;
  logic          q_valid;

  sd_adc_decimator #(
    .signalwidth (SW),
    .ratelog2    (RL2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (d),
    .fb      (fb),
    .q       (q),
    .q_valid (q_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Edge count since reset release and the d value applied before each edge.
  int            e;
  bit            dh [0:MAXE];
  logic [SW-1:0] q_model;
  bit            strobe_exp;

  typedef struct {
    logic [3:0]    pat;
    logic [SW-1:0] q_exp;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, expv, e);
  endtask

  // Bit x_m integrated at edge m is d applied before edge m-3. A 2nd-order CIC
  // result for the tick at edge T is the sum, over the R edges ending at T-2,
  // of R-wide boxcar sums of x.
  function automatic int window_c2(input int t);
    int s;
    s = 0;
    for (int p = t - 1 - R; p <= t - 2; p++)
      for (int m = p - R + 1; m <= p; m++)
        if (m >= 4) s += int'(dh[m-3]);
    return s;
  endfunction

  function automatic logic [SW-1:0] ref_q(input int c2);
    int v;
    v = (c2 > R * R - 1) ? R * R - 1 : c2;
    return SW'(v << (SW - 2 * RL2));
  endfunction

  // One clock: drive d, advance the model, compare all outputs at negedge.
  task automatic step(input bit dv);
    d = dv;
    @(posedge clk);
    e++;
    dh[e] = dv;
    strobe_exp = (e >= 3 * R + 2) && ((e - 2) % R == 0);
    if (strobe_exp) q_model = ref_q(window_c2(e - 2));
    @(negedge clk);
    check("fb", fb, (e >= 3) ? 32'(dh[e-2]) : 32'd0);
    check("q_valid", q_valid, 32'(strobe_exp));
    check("q", q, q_model);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset_n = 1'b0;
    d = 1'b0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    e = 0;
    check("rst_fb", fb, 0);
    check("rst_q", q, 0);
    check("rst_q_valid", q_valid, 0);
    reset_n = 1'b1;
    q_model = '0;
  endtask

  initial begin
    int            nstrobe;
    int            last_e;
    int            first_e;
    int            fb_rise_e;
    int            step_e;
    int            dens;
    logic [SW-1:0] prev_q;

    tbl[0] = '{4'b0000, 16'h0000};
    tbl[1] = '{4'b1111, 16'hFF00};
    tbl[2] = '{4'b0101, 16'h8000};
    tbl[3] = '{4'b0001, 16'h4000};
    tbl[4] = '{4'b0111, 16'hC000};
    tbl[5] = '{4'b0011, 16'h8000};

    // Periodic patterns: exact steady-state values and strobe count.
    for (int k = 0; k < 6; k++) begin
      do_reset(2);
      nstrobe = 0;
      for (int c = 0; c < 8 * R; c++) begin
        step(tbl[k].pat[(e + 1) % 4]);
        if (q_valid) begin
          nstrobe++;
          if (e >= 5 * R + 2) check("table_q", q, tbl[k].q_exp);
        end
      end
      check("table_strobes", nstrobe, 5);
    end

    // d held high for a long run: clamped full scale, fixed spacing, no wrap.
    do_reset(3);
    last_e = -1;
    for (int c = 0; c < 10000; c++) begin
      step(1'b1);
      if (q_valid) begin
        if (last_e >= 0) check("spacing", e - last_e, R);
        if (e >= 5 * R + 2) check("full_scale", q, 16'hFF00);
        last_e = e;
      end
    end

    // Step 0 -> 1 right after a strobe: fb latency, monotonic rise.
    do_reset(2);
    for (int c = 0; c < 5 * R + 2; c++) step(1'b0);
    step_e    = e + 1;
    fb_rise_e = -1;
    nstrobe   = 0;
    prev_q    = q;
    for (int c = 0; c < 6 * R; c++) begin
      step(1'b1);
      if (fb && fb_rise_e < 0) fb_rise_e = e;
      if (q_valid) begin
        nstrobe++;
        check("monotonic", 32'(q >= prev_q), 1);
        prev_q = q;
        if (nstrobe == 3) check("step_reach", q, 16'hFF00);
      end
    end
    check("fb_latency", fb_rise_e - step_e, 2);

    // Random density bitstream against the reference.
    do_reset(2);
    dens = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) dens = $urandom_range(0, 8);
      step(($urandom_range(0, 7) < dens) ? 1'b1 : 1'b0);
    end

    // One-clock reset at phase 7 mid-stream, then re-priming.
    while (!(e >= 5 * R && e % R == 7)) step(1'($urandom_range(0, 1)));
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_q", q, 0);
    check("midrst_q_valid", q_valid, 0);
    check("midrst_fb", fb, 0);
    reset_n = 1'b1;
    e = 0;
    q_model = '0;
    first_e = -1;
    for (int c = 0; c < 5 * R; c++) begin
      step(1'($urandom_range(0, 1)));
      if (q_valid && first_e < 0) first_e = e;
    end
    check("midrst_first_strobe", first_e, 3 * R + 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
